// File: rtl/rs_pkg.sv
// Reed-Solomon GF(2^M) defaults and elaboration-time helpers
// for constant multipliers.
package rs_pkg;

    localparam int RS_M = 10;
    localparam int RS_N = 544;
    localparam int RS_K = 514;
    localparam logic [RS_M:0] RS_PRIM_POLY = 11'h409;

    typedef logic [RS_M-1:0] sym_t;

    // Shift-and-reduce product a*c in GF(2^m).
    function automatic int gf_mul_const(
        input int a,
        input int c,
        input int m,
        input int poly
    );
        int r;
        int x;
        r = 0;
        x = a;
        for (int i = 0; i < m; i++) begin
            if (c[i]) r = r ^ x;
            x = x << 1;
            if (x[m]) x = x ^ poly;
        end
        return r;
    endfunction

    function automatic int gf_alpha_pow(
        input int e,
        input int m,
        input int poly
    );
        int r;
        int ee;
        ee = e % ((1 << m) - 1);
        r = 1;
        for (int i = 0; i < ee; i++) begin
            r = r << 1;
            if (r[m]) r = r ^ poly;
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_gf_cmul.sv
// Combinational GF(2^M) multiply by an elaboration-time constant,
// built as an XOR of pre-reduced columns CONST*x^k.
module rs_gf_cmul import rs_pkg::*; #(
    parameter int M = RS_M,
    parameter logic [M:0] PRIM_POLY = RS_PRIM_POLY,
    parameter int CONST = 1
) (
    input  logic [M-1:0] a_i,
    output logic [M-1:0] y_o
);

    logic [M-1:0] col [M];

    for (genvar k = 0; k < M; k++) begin : g_col
        localparam logic [M-1:0] COL =
            M'(gf_mul_const(CONST, 1 << k, M, int'(PRIM_POLY)));
        assign col[k] = a_i[k] ? COL : '0;
    end

    always_comb begin
        y_o = '0;
        for (int k = 0; k < M; k++) begin
            y_o = y_o ^ col[k];
        end
    end

endmodule

// File: rtl/rs_syn_par.sv
// Parallel Horner syndrome calculator: P symbols per beat,
// held result register with zero flag and early-sop abort.
module rs_syn_par import rs_pkg::*; #(
    parameter int M = RS_M,
    parameter int N = RS_N,
    parameter int K = RS_K,
    parameter int P = 1,
    parameter int FCR = 0,
    parameter logic [M:0] PRIM_POLY = RS_PRIM_POLY,
    localparam int NSYM = N - K
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sop,
    input  logic                       valid_in,
    input  logic [P*M-1:0]             data_in,
    output logic                       syn_valid,
    output logic [NSYM-1:0][M-1:0]     syndromes,
    output logic                       syn_zero,
    output logic                       short_err
);

    localparam int BEATS = N / P;
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic in_pkt_q, in_pkt_d;
    logic syn_valid_q, syn_zero_q, short_q;
    logic [NSYM-1:0][M-1:0] syn_q;

    logic [M-1:0] acc_q [NSYM];
    logic [M-1:0] acc_d [NSYM];
    logic [M-1:0] fb_in [NSYM];
    logic [M-1:0] fb_out [NSYM];
    logic [M-1:0] lane_out [NSYM][P];

    logic accept, last_beat, zero_d;

    for (genvar i = 0; i < NSYM; i++) begin : g_syn
        logic [M-1:0] nxt;

        // sop restarts Horner from zero instead of the stale sum
        assign fb_in[i] = sop ? '0 : acc_q[i];

        rs_gf_cmul #(
            .M(M),
            .PRIM_POLY(PRIM_POLY),
            .CONST(gf_alpha_pow((FCR + i) * P, M, int'(PRIM_POLY)))
        ) u_fb (
            .a_i(fb_in[i]),
            .y_o(fb_out[i])
        );

        for (genvar j = 0; j < P; j++) begin : g_lane
            rs_gf_cmul #(
                .M(M),
                .PRIM_POLY(PRIM_POLY),
                .CONST(gf_alpha_pow((FCR + i) * (P - 1 - j), M,
                                    int'(PRIM_POLY)))
            ) u_ln (
                .a_i(data_in[j*M +: M]),
                .y_o(lane_out[i][j])
            );
        end

        always_comb begin
            nxt = fb_out[i];
            for (int j = 0; j < P; j++) begin
                nxt = nxt ^ lane_out[i][j];
            end
        end

        assign acc_d[i] = nxt;
    end

    assign accept = valid_in && (sop || in_pkt_q);
    assign last_beat = valid_in && in_pkt_q && !sop && (cnt_q == LAST);

    always_comb begin
        zero_d = 1'b1;
        for (int i = 0; i < NSYM; i++) begin
            if (acc_d[i] != '0) zero_d = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        in_pkt_d = in_pkt_q;
        if (accept) begin
            if (sop) begin
                cnt_d = CW'(1);
                in_pkt_d = 1'b1;
            end else if (last_beat) begin
                cnt_d = '0;
                in_pkt_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            in_pkt_q <= 1'b0;
            syn_valid_q <= 1'b0;
            syn_zero_q <= 1'b0;
            short_q <= 1'b0;
            syn_q <= '0;
            for (int i = 0; i < NSYM; i++) acc_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
            in_pkt_q <= in_pkt_d;
            syn_valid_q <= last_beat;
            short_q <= valid_in && sop && in_pkt_q;
            if (accept) begin
                for (int i = 0; i < NSYM; i++) acc_q[i] <= acc_d[i];
            end
            if (last_beat) begin
                for (int i = 0; i < NSYM; i++) syn_q[i] <= acc_d[i];
                syn_zero_q <= zero_d;
            end
        end
    end

    assign syn_valid = syn_valid_q;
    assign syndromes = syn_q;
    assign syn_zero = syn_zero_q;
    assign short_err = short_q;

endmodule

// File: tb/tb_rs_syn_par.sv
// Bench for rs_syn_par: P=1 and P=4 instances against a
// direct polynomial-evaluation model with log/antilog tables.
module tb_rs_syn_par;

    localparam int M = 10;
    localparam int N = 544;
    localparam int NS = 30;
    localparam int FCR = 0;
    localparam int Q = 1023;

    typedef logic [NS-1:0][M-1:0] synv_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic v0 = 1'b0, s0 = 1'b0;
    logic [M-1:0] d0 = '0;
    logic v1 = 1'b0, s1 = 1'b0;
    logic [4*M-1:0] d1 = '0;
    logic sv0, sz0, se0, sv1, sz1, se1;
    synv_t sy0, sy1;

    always #5 clk = ~clk;

    rs_syn_par #(.P(1)) u_p1 (
        .clk(clk), .rst_n(rst_n), .sop(s0), .valid_in(v0),
        .data_in(d0), .syn_valid(sv0), .syndromes(sy0),
        .syn_zero(sz0), .short_err(se0)
    );

    rs_syn_par #(.P(4)) u_p4 (
        .clk(clk), .rst_n(rst_n), .sop(s1), .valid_in(v1),
        .data_in(d1), .syn_valid(sv1), .syndromes(sy1),
        .syn_zero(sz1), .short_err(se1)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int exp_t [Q];
    int log_t [1024];
    int g [NS+1];
    logic [M-1:0] cw [N];

    int mq0[$], mq1[$];
    bit m_in [2];
    bit e_val [2];
    bit e_short [2];
    bit e_zero [2];
    synv_t e_syn [2];
    int se_cnt = 0;

    task automatic chk(input string nm, input logic [NS*M-1:0] act,
                       input logic [NS*M-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic int gf_mul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return exp_t[(log_t[a] + log_t[b]) % Q];
    endfunction

    // r(x) with symbol k carrying power N-1-k, evaluated at each root
    function automatic synv_t eval_syn(input int s[$]);
        synv_t r;
        int acc;
        for (int i = 0; i < NS; i++) begin
            acc = 0;
            for (int k = 0; k < N; k++) begin
                acc = acc ^ gf_mul(s[k], exp_t[((FCR + i) * (N - 1 - k)) % Q]);
            end
            r[i] = M'(acc);
        end
        return r;
    endfunction

    task automatic model_step(input int d, input bit v, input bit sp,
                              input int syms[$]);
        int q[$];
        if (d == 0) q = mq0; else q = mq1;
        e_val[d] = 1'b0;
        e_short[d] = 1'b0;
        if (v) begin
            if (sp) begin
                e_short[d] = m_in[d];
                q = syms;
                m_in[d] = 1'b1;
            end else if (m_in[d]) begin
                foreach (syms[k]) q.push_back(syms[k]);
                if (q.size() == N) begin
                    e_syn[d] = eval_syn(q);
                    e_zero[d] = (e_syn[d] == '0);
                    e_val[d] = 1'b1;
                    m_in[d] = 1'b0;
                    q.delete();
                end
            end
        end
        if (d == 0) mq0 = q; else mq1 = q;
    endtask

    always @(negedge clk) begin
        int sy[$];
        if (!rst_n) begin
            mq0.delete();
            mq1.delete();
            for (int d = 0; d < 2; d++) begin
                m_in[d] = 0; e_val[d] = 0; e_short[d] = 0;
                e_zero[d] = 0; e_syn[d] = '0;
            end
        end
        chk("p1_syn_valid", NS'(sv0), NS'(e_val[0]));
        chk("p1_short_err", NS'(se0), NS'(e_short[0]));
        chk("p1_syndromes", sy0, e_syn[0]);
        chk("p1_syn_zero", NS'(sz0), NS'(e_zero[0]));
        chk("p4_syn_valid", NS'(sv1), NS'(e_val[1]));
        chk("p4_short_err", NS'(se1), NS'(e_short[1]));
        chk("p4_syndromes", sy1, e_syn[1]);
        chk("p4_syn_zero", NS'(sz1), NS'(e_zero[1]));
        if (rst_n) begin
            sy.delete();
            sy.push_back(int'(d0));
            model_step(0, v0, s0, sy);
            sy.delete();
            for (int j = 0; j < 4; j++) sy.push_back(int'(d1[j*M +: M]));
            model_step(1, v1, s1, sy);
        end
    end

    always @(negedge clk) if (se0 === 1'b1) se_cnt++;

    task automatic send(input int d, input int gap, input int abort_at);
        int p;
        p = (d == 0) ? 1 : 4;
        for (int b = 0; b < N / p; b++) begin
            if (b == abort_at) break;
            while ($urandom_range(99) < gap) begin
                v0 = 0; v1 = 0;
                @(posedge clk); #1;
            end
            if (d == 0) begin
                v0 = 1; s0 = (b == 0); d0 = cw[b];
            end else begin
                v1 = 1; s1 = (b == 0);
                for (int j = 0; j < 4; j++) d1[j*M +: M] = cw[b*4 + j];
            end
            @(posedge clk); #1;
        end
        v0 = 0; s0 = 0; v1 = 0; s1 = 0;
    endtask

    task automatic clear_cw();
        for (int k = 0; k < N; k++) cw[k] = '0;
    endtask

    // systematic encoder: message high powers first, then parity
    task automatic encode_random(input int nerr);
        int par [NS];
        int fb;
        for (int j = 0; j < NS; j++) par[j] = 0;
        for (int k = 0; k < N - NS; k++) begin
            cw[k] = M'($urandom_range(1023));
            fb = int'(cw[k]) ^ par[NS-1];
            for (int j = NS - 1; j > 0; j--) par[j] = par[j-1] ^ gf_mul(fb, g[j]);
            par[0] = gf_mul(fb, g[0]);
        end
        for (int j = 0; j < NS; j++) cw[N - NS + j] = M'(par[NS - 1 - j]);
        for (int e = 0; e < nerr; e++) begin
            cw[$urandom_range(N - 1)] ^= M'($urandom_range(1023, 1));
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int x;
        int se_base;
        synv_t ones;
        x = 1;
        for (int e = 0; e < Q; e++) begin
            exp_t[e] = x;
            log_t[x] = e;
            x = x << 1;
            if ((x & 1024) != 0) x = x ^ 'h409;
        end
        for (int j = 0; j <= NS; j++) g[j] = 0;
        g[0] = 1;
        for (int i = 0; i < NS; i++) begin
            for (int k = i + 1; k > 0; k--) begin
                g[k] = g[k-1] ^ gf_mul(g[k], exp_t[(FCR + i) % Q]);
            end
            g[0] = gf_mul(g[0], exp_t[(FCR + i) % Q]);
        end
        for (int i = 0; i < NS; i++) ones[i] = 10'h001;

        chk("tbl_alpha10", NS'(exp_t[10]), NS'(10'h009));
        chk("tbl_alpha1023", NS'(gf_mul(exp_t[1022], 2)), NS'(1));

        cycles(3);
        chk("rst_syn_valid", NS'(sv0), '0);
        chk("rst_syndromes", sy0, '0);
        rst_n = 1;
        cycles(2);

        clear_cw();
        send(0, 0, -1);
        chk("zero_cw_valid", NS'(sv0), NS'(1));
        chk("zero_cw_syn", sy0, '0);
        chk("zero_cw_flag", NS'(sz0), NS'(1));
        cycles(2);

        cw[N-1] = 10'h001;
        send(0, 0, -1);
        chk("x0_err_p1", sy0, ones);
        chk("x0_err_p1_zero", NS'(sz0), '0);
        send(1, 0, -1);
        chk("x0_err_p4", sy1, ones);

        clear_cw();
        cw[0] = 10'h001;
        send(0, 0, -1);
        chk("x543_s0", NS'(sy0[0]), NS'(10'h001));
        chk("x543_s1", NS'(sy0[1]), NS'(exp_t[543]));

        encode_random(0);
        send(0, 0, -1);
        chk("enc_p1_zero", NS'(sz0), NS'(1));
        send(1, 0, -1);
        chk("enc_p4_zero", NS'(sz1), NS'(1));

        for (int c = 0; c < 3; c++) begin
            encode_random(c);
            send(0, 30, -1);
        end
        for (int c = 0; c < 4; c++) begin
            encode_random(c % 3);
            send(1, (c < 2) ? 0 : 30, -1);
        end
        cycles(2);

        se_base = se_cnt;
        encode_random(1);
        send(0, 0, 100);
        encode_random(2);
        send(0, 0, -1);
        cycles(2);
        chk("abort_short_cnt", NS'(se_cnt - se_base), NS'(1));

        encode_random(3);
        send(0, 0, 300);
        rst_n = 0;
        #1;
        chk("rst_mid_syn", sy0, '0);
        chk("rst_mid_zero", NS'(sz0), '0);
        cycles(2);
        rst_n = 1;
        v0 = 1; s0 = 0; d0 = 10'h3a5;
        cycles(5);
        v0 = 0;
        chk("rst_nosop_ignored", sy0, '0);
        encode_random(1);
        send(0, 20, -1);
        cycles(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
